// File: rtl/pair_xfer_engine.sv
// Pairwise memory-to-memory transfer engine: words loaded into A are combined two at a time
// (A[2k], A[2k+1]) and the results are stored in B, which has a registered read port.
module pair_xfer_engine #(
  parameter int unsigned W    = 8,
  parameter int unsigned AW_A = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [W-1:0]    load_data,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [AW_A-2:0] rd_addr,
  output logic [W-1:0]    rd_data,
  output logic            a_full,
  output logic            busy,
  output logic            done,
  output logic            ovf
);

  localparam int unsigned AW_B  = AW_A - 1;
  localparam int unsigned NA    = 2 ** AW_A;
  localparam int unsigned NPAIR = 2 ** AW_B;

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StCalc, StWr, StFin} state_e;

  state_e          state_q;
  logic [AW_A-1:0] wptr_q;
  logic [AW_B-1:0] k_q;
  logic [1:0]      mode_q;
  logic [W-1:0]    a_rdata_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    r_q;
  logic            c_q;

  logic [W-1:0] mem_a [NA];
  logic [W-1:0] mem_b [NPAIR];

  logic            start_ok;
  logic            load_ok;
  logic [AW_A-1:0] a_raddr;
  logic [W:0]      sum;
  logic [W:0]      diff;
  logic [W-1:0]    res;
  logic            carry;

  assign start_ok = start && (state_q == StIdle) && a_full;
  // A simultaneous load is dropped when the start is accepted.
  assign load_ok  = load_en && (state_q == StIdle) && !start_ok;
  assign a_raddr  = {k_q, (state_q == StRd1)};

  // During CALC, a_rdata_q holds y = A[2k+1]; diff[W] is the borrow, i.e. x < y.
  assign sum  = {1'b0, x_q} + {1'b0, a_rdata_q};
  assign diff = {1'b0, x_q} - {1'b0, a_rdata_q};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    unique case (mode_q)
      2'd0: begin
        if (diff[W]) begin
          res   = sum[W-1:0];
          carry = sum[W];
        end else begin
          res   = diff[W-1:0];
        end
      end
      2'd1: begin
        res   = sum[W-1:0];
        carry = sum[W];
      end
      2'd2: res = diff[W] ? (a_rdata_q - x_q) : diff[W-1:0];
      2'd3: res = diff[W] ? a_rdata_q : x_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      k_q     <= '0;
      mode_q  <= 2'd0;
      x_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      a_full  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            mode_q  <= mode;
            ovf     <= 1'b0;
            k_q     <= '0;
            busy    <= 1'b1;
            state_q <= StRd0;
          end else if (load_ok) begin
            wptr_q <= wptr_q + 1'b1;
            if (&wptr_q) a_full <= 1'b1;
          end
        end
        StRd0: state_q <= StRd1;
        StRd1: begin
          x_q     <= a_rdata_q;
          state_q <= StCalc;
        end
        StCalc: begin
          r_q     <= res;
          c_q     <= carry;
          state_q <= StWr;
        end
        StWr: begin
          ovf <= ovf | c_q;
          k_q <= k_q + 1'b1;
          if (&k_q) begin
            state_q <= StFin;
            done    <= 1'b1;
            a_full  <= 1'b0;
          end else begin
            state_q <= StRd0;
          end
        end
        StFin: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory arrays are not reset.
  always_ff @(posedge clk) begin
    if (load_ok) mem_a[wptr_q] <= load_data;
    a_rdata_q <= mem_a[a_raddr];
    if (state_q == StWr) mem_b[k_q] <= r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem_b[rd_addr];
  end

endmodule

// File: tb/tb_pair_xfer_engine.sv
// Randomised and directed bench for pair_xfer_engine against a word-level reference model.
module tb_pair_xfer_engine;

  localparam int NA    = 8;
  localparam int NPAIR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] load_data = '0;
  logic       start = 1'b0;
  logic [1:0] mode = '0;
  logic [1:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       a_full, busy, done, ovf;

  pair_xfer_engine #(.W(8), .AW_A(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_data (load_data),
    .start     (start),
    .mode      (mode),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .a_full    (a_full),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_a [NA];
  int m_b [NPAIR];
  bit m_bv [NPAIR];
  bit m_full;
  int m_wptr;
  bit m_ovf;
  int vec [NA];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int combine(input int md, input int x, input int y, output bit c);
    c = 1'b0;
    case (md)
      0: begin
        if (x < y) begin
          c = (x + y) > 255;
          return (x + y) % 256;
        end
        return x - y;
      end
      1: begin
        c = (x + y) > 255;
        return (x + y) % 256;
      end
      2: return (x > y) ? x - y : y - x;
      default: return (x > y) ? x : y;
    endcase
  endfunction

  function automatic void model_load(input int d);
    m_a[m_wptr] = d & 255;
    m_wptr = (m_wptr + 1) % NA;
    if (m_wptr == 0) m_full = 1'b1;
  endfunction

  task automatic load_word(input int d);
    load_en   = 1'b1;
    load_data = 8'(d);
    @(negedge clk);
    load_en = 1'b0;
    model_load(d);
    check_eq("a_full", a_full, m_full);
  endtask

  task automatic load_vec();
    for (int i = 0; i < NA; i++) load_word(vec[i]);
  endtask

  task automatic check_b();
    for (int i = 0; i < NPAIR; i++) begin
      rd_addr = 2'(i);
      @(negedge clk);
      if (m_bv[i]) check_eq($sformatf("rd_b%0d", i), rd_data, m_b[i]);
    end
  endtask

  // abort_at > 0 pulls reset low at that busy cycle.
  task automatic run_xfer(input int md, input bit with_load, input int abort_at);
    bit acc;
    int cnt, dcnt, dat, pairs, old_b1;
    bit old_v, nc, c;
    int nb [NPAIR];
    bit aborted;
    acc = m_full;
    rd_addr   = 2'd1;
    start     = 1'b1;
    mode      = 2'(md);
    load_en   = with_load;
    load_data = 8'hA5;
    @(negedge clk);
    start   = 1'b0;
    load_en = 1'b0;
    mode    = 2'($urandom);
    if (!acc) begin
      if (with_load) model_load(8'hA5);
      check_eq("no_busy", busy, 0);
      repeat (3) begin
        @(negedge clk);
        check_eq("no_busy_later", busy, 0);
      end
      check_eq("a_full_idle", a_full, m_full);
      return;
    end
    old_b1 = m_b[1];
    old_v  = m_bv[1];
    nc     = 1'b0;
    for (int k = 0; k < NPAIR; k++) begin
      nb[k] = combine(md, m_a[2*k], m_a[2*k+1], c);
      nc    = nc | c;
    end
    cnt = 0; dcnt = 0; dat = 0; aborted = 1'b0;
    while (busy && cnt < 100) begin
      cnt++;
      if (done) begin
        dcnt++;
        dat = cnt;
      end
      if (cnt == 9 && old_v) check_eq("rd_collide_old", rd_data, old_b1);
      if (cnt == 10) check_eq("rd_after_wr", rd_data, nb[1]);
      if (cnt == abort_at) begin
        start   = 1'b0;
        load_en = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_a_full", a_full, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1'b1;
        break;
      end
      start     = 1'($urandom);
      load_en   = 1'($urandom);
      load_data = 8'($urandom);
      mode      = 2'($urandom);
      @(negedge clk);
    end
    start   = 1'b0;
    load_en = 1'b0;
    if (aborted) begin
      pairs  = (abort_at - 1) / 4;
      m_full = 1'b0;
      m_wptr = 0;
      m_ovf  = 1'b0;
    end else begin
      pairs = NPAIR;
      check_eq("busy_cycles", cnt, 4 * NPAIR + 1);
      check_eq("done_pulses", dcnt, 1);
      check_eq("done_last", dat, cnt);
      check_eq("done_after", done, 0);
      m_ovf  = nc;
      m_full = 1'b0;
      check_eq("ovf", ovf, m_ovf);
      check_eq("a_full_clr", a_full, 0);
    end
    for (int k = 0; k < pairs; k++) begin
      m_b[k]  = nb[k];
      m_bv[k] = 1'b1;
    end
  endtask

  initial begin
    m_full = 1'b0;
    m_wptr = 0;
    m_ovf  = 1'b0;
    for (int i = 0; i < NPAIR; i++) m_bv[i] = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_a_full", a_full, 0);
    check_eq("reset_ovf", ovf, 0);
    check_eq("reset_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vec = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_vec();
    run_xfer(0, 1'b0, 0);
    check_b();

    vec = '{9, 4, 20, 6, 8, 8, 2, 250};
    load_vec();
    run_xfer(0, 1'b0, 0);
    check_b();
    load_vec();
    run_xfer(2, 1'b0, 0);
    check_b();

    vec = '{200, 100, 255, 1, 0, 0, 128, 128};
    load_vec();
    run_xfer(1, 1'b0, 0);
    check_b();
    load_vec();
    run_xfer(3, 1'b0, 0);
    check_b();

    // Early start is ignored; start with a concurrent load wins once full.
    for (int i = 0; i < 5; i++) load_word(10 + 7 * i);
    run_xfer(1, 1'b0, 0);
    check_b();
    for (int i = 0; i < 3; i++) load_word(90 + 50 * i);
    run_xfer(1, 1'b1, 0);
    check_b();

    // Reset during the third pair, then a start without reload.
    for (int i = 0; i < NA; i++) load_word($urandom_range(0, 255));
    run_xfer(2, 1'b0, 10);
    check_b();
    run_xfer(0, 1'b0, 0);
    check_b();

    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(3, 14);
      for (int i = 0; i < n; i++) load_word($urandom_range(0, 255));
      run_xfer($urandom_range(0, 3), 1'($urandom), 0);
      check_b();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pair_xfer_engine.md
Name: pair_xfer_engine

Overview:
- Parametrised memory-to-memory transfer engine that folds controller, source/destination address counters, both memories, delay register, arithmetic unit and result mux into one block.
- Source memory A (2^AW_A words) is loaded by a write stream. On start, consecutive word pairs (A[2k], A[2k+1]) are combined per a selectable mode and written to destination memory B (2^(AW_A-1) words), which is readable through a registered port.

Parameters:
- W, 8, data width of both memories and of the result.
- AW_A, 3, memory A address width; must be >= 2. Memory A holds 2^AW_A words.
- Derived localparams: AW_B = AW_A-1; NPAIR = 2^AW_B.

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- load_en  in  1  writes load_data to memory A at the internal load pointer; honoured only in IDLE.
- load_data  in  W  source word.
- start  in  1  transfer request; honoured only in IDLE with a_full=1.
- mode  in  2  combine mode, latched on the accepted start.
- rd_addr  in  AW_B  memory B read address.
- rd_data  out  W  memory B read data, 1-cycle latency.
- a_full  out  1  all 2^AW_A words of A written since reset or last transfer.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- ovf  out  1  sticky arithmetic overflow for the last transfer.

Behaviour:
- Reset low (async) clears: FSM to IDLE, load pointer, pair index k, a_full, busy, done, ovf, rd_data to 0. Memory contents are not reset.
- Load (IDLE only):
  - On load_en: A[wptr] <= load_data; wptr increments and wraps at 2^AW_A.
  - a_full sets when the write to address 2^AW_A-1 completes, i.e. wptr wrapping to 0.
  - Further loads while full overwrite from address 0; a_full stays 1.
- Start:
  - Accepted when start=1, state IDLE and a_full=1. Otherwise ignored, with no flag.
  - If start and load_en are both high in an accepted cycle, start wins and the load is dropped.
  - Accepted start latches mode, clears ovf and k, and sets busy on the next edge.
- FSM: IDLE -> RD0 -> RD1 -> CALC -> WR -> (RD0 if k<NPAIR-1, else FIN) ; FIN -> IDLE.
  - RD0: present address 2k to A, which has synchronous read.
  - RD1: capture x=A[2k]; present address 2k+1.
  - CALC: capture y=A[2k+1]; register result r and carry/borrow c.
  - WR: B[k] <= r; ovf <= ovf | c; k++.
  - FIN: done=1 for this single cycle; busy drops on the same edge that leaves FIN.
  - Total: busy high exactly 4*NPAIR+1 cycles; done on the last busy cycle.
- Modes (all arithmetic modulo 2^W):
  - 0 sign-select: if x<y then r=x+y, c=carry; else r=x-y, c=0.
  - 1 sum: r=x+y, c=carry.
  - 2 absolute difference: r=|x-y|, c=0.
  - 3 max: r=max(x,y), c=0.
- While busy:
  - load_en, start and mode are ignored.
  - a_full clears in FIN, so a new full load is required before the next start.
- Read port:
  - rd_data <= B[rd_addr] every cycle regardless of state.
  - A read of B[k] in the same cycle as its WR returns the old value.
- Reset mid-transfer: everything returns to reset values immediately, and done is not generated. B keeps the words already written; the partly computed word is lost.

Test Plan:
- Reset, load 1..8, mode=0, start → B = {3,7,11,15}. busy high 17 cycles, done one pulse, ovf=0.
- Load 9,4,20,6,8,8,2,250, mode=0 → B = {5,14,0,252}, ovf=0. Repeat the load with mode=2 → B = {5,14,0,248}.
- Load 200,100,255,1,0,0,128,128, mode=1 → B = {44,0,0,0}, ovf=1. Load again, mode=3 → B = {200,255,0,128}, ovf=0.
- Assert start after only 5 loads → no busy, B unchanged. Then 3 more loads and start → transfer runs. Start pulses while busy are ignored.
- Pull Reset low during the third pair → busy=0, done=0, a_full=0 immediately. B[0..1] hold new values, B[2..3] hold old values. A subsequent start without reload is ignored.
- Read B[1] with rd_addr=1 → rd_data valid exactly one cycle later. A read colliding with WR of B[1] returns the pre-write value.
